// File: rtl/id_issue_queue_pkg.sv
// Shared types for the decode->issue queue: scoreboard payload, queue slot, interrupt source count.
package id_issue_queue_pkg;

  localparam int unsigned NumInterruptSrc = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
  } scoreboard_entry_t;

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              is_ctrl_flow;
  } idq_entry_t;

endpackage

// File: rtl/irq_onehot_decoder.sv
// CLIC capture: registers the one-hot irq vector and level, encodes the id, qualifies the request.
module irq_onehot_decoder import id_issue_queue_pkg::*; #(
  parameter int unsigned NumIrqSrc = NumInterruptSrc
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumIrqSrc-1:0]         irq_i,
  input  logic [7:0]                   irq_level_i,
  input  logic [7:0]                   mintthresh_i,
  input  logic [7:0]                   mil_i,
  input  logic                         mie_i,
  output logic                         irq_req_o,
  output logic [$clog2(NumIrqSrc)-1:0] irq_id_o,
  output logic [7:0]                   irq_level_o,
  output logic                         irq_onehot_err_o
);

  localparam int unsigned IdW = $clog2(NumIrqSrc);

  logic [NumIrqSrc-1:0] irq_p1;
  logic [7:0]           level_p1;

  function automatic logic [7:0] max_lvl(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Stage p1: capture vector and level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_p1   <= '0;
      level_p1 <= '0;
    end else begin
      irq_p1   <= irq_i;
      level_p1 <= irq_level_i;
    end
  end

  // OR-reduction encoder also yields a defined id when the vector is not one-hot.
  always_comb begin
    irq_id_o = '0;
    for (int unsigned i = 0; i < NumIrqSrc; i++) begin
      for (int unsigned j = 0; j < IdW; j++) begin
        if (i[j]) irq_id_o[j] = irq_id_o[j] | irq_p1[i];
      end
    end
  end

  assign irq_level_o      = level_p1;
  assign irq_req_o        = (level_p1 > max_lvl(mintthresh_i, mil_i)) && (|irq_p1) && mie_i;
  assign irq_onehot_err_o = !$onehot0(irq_p1);

endmodule

// File: rtl/id_issue_queue.sv
// Depth-entry decode->issue FIFO with ctrl-flow tag, plus CLIC interrupt capture.
// Optional IDQ_BYPASS_EN: an empty queue forwards entry_i to the head in the same cycle.
module id_issue_queue import id_issue_queue_pkg::*; #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned NumIrqSrc = NumInterruptSrc,
  parameter type         entry_t   = scoreboard_entry_t
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  entry_t                       entry_i,
  input  logic                         is_ctrl_flow_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output entry_t                       entry_o,
  output logic                         is_ctrl_flow_o,
  output logic                         valid_o,
  input  logic                         ack_i,
  output logic [$clog2(Depth+1)-1:0]   usage_o,
  input  logic [NumIrqSrc-1:0]         irq_i,
  input  logic [7:0]                   irq_level_i,
  input  logic [7:0]                   mintthresh_i,
  input  logic [7:0]                   mil_i,
  input  logic                         mie_i,
  output logic                         irq_req_o,
  output logic [$clog2(NumIrqSrc)-1:0] irq_id_o,
  output logic [7:0]                   irq_level_o,
  output logic                         irq_onehot_err_o
);

  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned UsageW = $clog2(Depth + 1);
  localparam logic [UsageW-1:0] DepthU = UsageW'(Depth);

  typedef struct packed {
    entry_t sbe;
    logic   is_ctrl_flow;
  } slot_t;

  slot_t             mem_q [Depth];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [UsageW-1:0] usage_q;
  logic              empty, bypass, push, pop, pop_mem;

  // Explicit wrap so non-power-of-2 depths never leave the array.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty = (usage_q == '0);
`ifdef IDQ_BYPASS_EN
    bypass         = empty && valid_i;
    valid_o        = !flush_i && (!empty || valid_i);
    entry_o        = bypass ? entry_i : mem_q[rd_ptr_q].sbe;
    is_ctrl_flow_o = bypass ? is_ctrl_flow_i : mem_q[rd_ptr_q].is_ctrl_flow;
`else
    bypass         = 1'b0;
    valid_o        = !flush_i && !empty;
    entry_o        = mem_q[rd_ptr_q].sbe;
    is_ctrl_flow_o = mem_q[rd_ptr_q].is_ctrl_flow;
`endif
    ready_o = !flush_i && ((usage_q < DepthU) || (ack_i && valid_o));
    pop     = ack_i && valid_o;
    pop_mem = pop && !empty;
    // A bypassed entry that is acknowledged immediately never touches storage.
    push    = valid_i && ready_o && !(bypass && pop);
  end

  // Stage p1: storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= slot_t'{sbe: entry_i, is_ctrl_flow: is_ctrl_flow_i};
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_mem) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop_mem)      usage_q <= usage_q + 1'b1;
      else if (!push && pop_mem) usage_q <= usage_q - 1'b1;
    end
  end

  assign usage_o = usage_q;

  irq_onehot_decoder #(
    .NumIrqSrc (NumIrqSrc)
  ) u_irq_dec (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .irq_i            (irq_i),
    .irq_level_i      (irq_level_i),
    .mintthresh_i     (mintthresh_i),
    .mil_i            (mil_i),
    .mie_i            (mie_i),
    .irq_req_o        (irq_req_o),
    .irq_id_o         (irq_id_o),
    .irq_level_o      (irq_level_o),
    .irq_onehot_err_o (irq_onehot_err_o)
  );

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue (Depth=4, NumIrqSrc=8) with a reference queue for the FIFO.
module tb_id_issue_queue;
  import id_issue_queue_pkg::*;

`ifdef IDQ_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  scoreboard_entry_t entry_i;
  logic              is_ctrl_flow_i;
  logic              valid_i;
  logic              ready_o;
  scoreboard_entry_t entry_o;
  logic              is_ctrl_flow_o;
  logic              valid_o;
  logic              ack_i;
  logic [2:0]        usage_o;
  logic [7:0]        irq_i;
  logic [7:0]        irq_level_i;
  logic [7:0]        mintthresh_i;
  logic [7:0]        mil_i;
  logic              mie_i;
  logic              irq_req_o;
  logic [2:0]        irq_id_o;
  logic [7:0]        irq_level_o;
  logic              irq_onehot_err_o;

  int n_chk  = 0;
  int n_pass = 0;
  idq_entry_t mq[$];

  id_issue_queue #(.Depth(4), .NumIrqSrc(8)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .entry_i          (entry_i),
    .is_ctrl_flow_i   (is_ctrl_flow_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .entry_o          (entry_o),
    .is_ctrl_flow_o   (is_ctrl_flow_o),
    .valid_o          (valid_o),
    .ack_i            (ack_i),
    .usage_o          (usage_o),
    .irq_i            (irq_i),
    .irq_level_i      (irq_level_i),
    .mintthresh_i     (mintthresh_i),
    .mil_i            (mil_i),
    .mie_i            (mie_i),
    .irq_req_o        (irq_req_o),
    .irq_id_o         (irq_id_o),
    .irq_level_o      (irq_level_o),
    .irq_onehot_err_o (irq_onehot_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic scoreboard_entry_t mk(input int k);
    scoreboard_entry_t t;
    t.pc = 32'h1000 + 32'(k) * 4;
    t.op = 8'(k);
    t.rd = 5'(k);
    return t;
  endfunction

  // One clock of FIFO traffic, checked against the reference queue.
  task automatic cycle(input logic v, input int k, input logic c, input logic a, input logic f);
    logic       mvalid, mready, mpush, mpop;
    idq_entry_t h;
    valid_i = v; entry_i = mk(k); is_ctrl_flow_i = c; ack_i = a; flush_i = f;
    mvalid = !f && (mq.size() > 0 || (Byp && v));
    mready = !f && (mq.size() < 4 || (a && mvalid));
    h = (mq.size() > 0) ? mq[0] : idq_entry_t'{sbe: mk(k), is_ctrl_flow: c};
    #1;
    check("ready", ready_o, mready);
    check("valid", valid_o, mvalid);
    if (mvalid) begin
      check("head_entry", 64'(entry_o), 64'(h.sbe));
      check("head_ctrl", is_ctrl_flow_o, h.is_ctrl_flow);
    end
    @(posedge clk_i); #1;
    if (f) mq.delete();
    else begin
      mpush = v && mready;
      mpop  = a && mvalid;
      if (mpop) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else mpush = 1'b0;
      end
      if (mpush) mq.push_back(idq_entry_t'{sbe: mk(k), is_ctrl_flow: c});
    end
    check("usage", usage_o, 64'(mq.size()));
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 0; entry_i = '0; is_ctrl_flow_i = 0; valid_i = 0; ack_i = 0;
    irq_i = '0; irq_level_i = '0; mintthresh_i = '0; mil_i = '0; mie_i = 0;
    #12;
    check("rst_valid", valid_o, 0);
    check("rst_usage", usage_o, 0);
    check("rst_entry", 64'(entry_o), 0);
    check("rst_ctrl", is_ctrl_flow_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_irq_req", irq_req_o, 0);
    check("rst_irq_id", irq_id_o, 0);
    check("rst_onehot_err", irq_onehot_err_o, 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Fill to full with no ack
    for (int k = 1; k <= 4; k++) cycle(1'b1, k, k[0], 1'b0, 1'b0);
    check("full_usage", usage_o, 4);
    check("full_ready", ready_o, 0);
    check("full_head", 64'(entry_o), 64'(mk(1)));
    check("full_head_ctrl", is_ctrl_flow_o, 1);
    // Push E while popping A at full
    cycle(1'b1, 5, 1'b0, 1'b1, 1'b0);
    check("full_pp_usage", usage_o, 4);
    check("full_pp_head", 64'(entry_o), 64'(mk(2)));
    for (int n = 0; n < 4; n++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    check("drain_valid", valid_o, 0);

    // Streaming with ack every cycle: pointers wrap
    for (int k = 10; k < 20; k++) begin
      cycle(1'b1, k, k[1], 1'b1, 1'b0);
      check("wrap_usage_le1", 64'(usage_o <= 3'd1), 1);
    end
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Flush with concurrent push and pop
    for (int k = 30; k < 33; k++) cycle(1'b1, k, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 40, 1'b1, 1'b1, 1'b1);
    valid_i = 0; ack_i = 0; flush_i = 0;
    #1;
    check("flush_valid", valid_o, 0);
    check("flush_usage", usage_o, 0);
    cycle(1'b1, 50, 1'b1, 1'b0, 1'b0);
    check("post_flush_head", 64'(entry_o), 64'(mk(50)));
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Empty queue, push with ack in the same cycle
    valid_i = 1; entry_i = mk(60); is_ctrl_flow_i = 1; ack_i = 1;
    #1;
`ifdef IDQ_BYPASS_EN
    check("byp_valid", valid_o, 1);
    check("byp_entry", 64'(entry_o), 64'(mk(60)));
    @(posedge clk_i); #1;
    check("byp_usage", usage_o, 0);
`else
    check("nobyp_valid", valid_o, 0);
    @(posedge clk_i); #1;
    check("nobyp_usage", usage_o, 1);
    mq.delete();
    mq.push_back(idq_entry_t'{sbe: mk(60), is_ctrl_flow: 1'b1});
`endif
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Interrupt path
    irq_i = 8'b0010_0000; irq_level_i = 8'd5; mintthresh_i = 8'd3; mil_i = 8'd4; mie_i = 1;
    #1;
    check("irq_latency_req", irq_req_o, 0);
    @(posedge clk_i); #1;
    check("irq_id5", irq_id_o, 5);
    check("irq_req5", irq_req_o, 1);
    check("irq_level5", irq_level_o, 5);
    check("irq_err5", irq_onehot_err_o, 0);
    mil_i = 8'd5; #1;
    check("irq_mil_eq", irq_req_o, 0);
    irq_i = 8'b0000_0110; mil_i = 8'd0; flush_i = 1;
    @(posedge clk_i); #1;
    check("irq_onehot_err", irq_onehot_err_o, 1);
    check("irq_id_multi", irq_id_o, 3);
    flush_i = 0;
    irq_i = 8'b1000_0000; irq_level_i = 8'd9; mintthresh_i = 8'd0; mie_i = 0;
    @(posedge clk_i); #1;
    check("irq_mie0", irq_req_o, 0);
    check("irq_id7", irq_id_o, 7);
    mie_i = 1; #1;
    check("irq_mie1", irq_req_o, 1);
    mintthresh_i = 8'd9; #1;
    check("irq_thresh_eq", irq_req_o, 0);
    irq_i = 8'b0000_0000;
    @(posedge clk_i); #1;
    check("irq_none_req", irq_req_o, 0);
    check("irq_none_err", irq_onehot_err_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
